// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start detect, oversampled bit timing and SIPO control strobes.
// Optional macro START_GLITCH_REJECT_EN aborts a frame whose start bit is high at mid-start.
module uart_rx_sequencer #(
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned CLKS_PER_BIT     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic serial_in_synced,
    output logic sampling_strobe,
    output logic data_is_available,
    output logic data_is_valid,
    output logic framing_error,
    output logic rx_busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(INPUT_DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(INPUT_DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             line_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_cnt_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_nxt;

    logic start_edge;
    logic half_hit;
    logic bit_wrap;

    logic strobe_nxt;
    logic avail_nxt;
    logic valid_nxt;
    logic ferr_nxt;
    logic busy_nxt;

    assign start_edge = line_prev & ~serial_in_synced;
    assign half_hit   = (clk_cnt == HALF_LAST);
    assign bit_wrap   = (clk_cnt == BIT_LAST);

    // State, counters and previous-line register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            line_prev <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            line_prev <= serial_in_synced;
            clk_cnt   <= clk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt + CNT_W'(1);
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                if (start_edge) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_hit) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
`ifdef START_GLITCH_REJECT_EN
                    state_nxt   = serial_in_synced ? IDLE : DATA;
`else
                    state_nxt   = DATA;
`endif
                end
            end
            DATA: begin
                if (bit_wrap) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_wrap) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                clk_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

    // Output decode; every output is registered one cycle later
    always_comb begin
        strobe_nxt = 1'b0;
        avail_nxt  = 1'b0;
        valid_nxt  = 1'b0;
        ferr_nxt   = 1'b0;
        busy_nxt   = (state != IDLE);
        case (state)
            DATA: begin
                avail_nxt  = 1'b1;
                strobe_nxt = bit_wrap;
            end
            STOP: begin
                strobe_nxt = bit_wrap;
                valid_nxt  = bit_wrap & serial_in_synced;
                ferr_nxt   = bit_wrap & ~serial_in_synced;
            end
            default: begin
                strobe_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sampling_strobe   <= 1'b0;
            data_is_available <= 1'b0;
            data_is_valid     <= 1'b0;
            framing_error     <= 1'b0;
            rx_busy           <= 1'b0;
        end else begin
            sampling_strobe   <= strobe_nxt;
            data_is_available <= avail_nxt;
            data_is_valid     <= valid_nxt;
            framing_error     <= ferr_nxt;
            rx_busy           <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: an 8-bit/16x instance and a 5-bit/4x instance,
// with a small SIPO model fed by sampling_strobe && data_is_available.
module tb_uart_rx_sequencer;

    logic clk;
    logic reset;
    logic line_a;
    logic line_b;

    logic strobe_a, avail_a, valid_a, ferr_a, busy_a;
    logic strobe_b, avail_b, valid_b, ferr_b, busy_b;

    int n_checks;
    int n_errors;
    int cyc;
    int t0_a;
    int t0_b;

    int          strb_a[$];
    int          strb_b[$];
    logic [7:0]  sh_a;
    logic [4:0]  sh_b;
    int          valid_cnt_a, valid_at_a, ferr_cnt_a, ferr_at_a, busy_last_a;
    int          valid_cnt_b, valid_at_b;

    uart_rx_sequencer #(.INPUT_DATA_WIDTH(8), .CLKS_PER_BIT(16)) dut_a (
        .clk               (clk),
        .reset             (reset),
        .serial_in_synced  (line_a),
        .sampling_strobe   (strobe_a),
        .data_is_available (avail_a),
        .data_is_valid     (valid_a),
        .framing_error     (ferr_a),
        .rx_busy           (busy_a)
    );

    uart_rx_sequencer #(.INPUT_DATA_WIDTH(5), .CLKS_PER_BIT(4)) dut_b (
        .clk               (clk),
        .reset             (reset),
        .serial_in_synced  (line_b),
        .sampling_strobe   (strobe_b),
        .data_is_available (avail_b),
        .data_is_valid     (valid_b),
        .framing_error     (ferr_b),
        .rx_busy           (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, times relative to each frame's cycle 0
    always @(negedge clk) begin
        if (strobe_a) strb_a.push_back(cyc - t0_a);
        if (strobe_a && avail_a) sh_a = {line_a, sh_a[7:1]};
        if (valid_a) begin valid_cnt_a++; valid_at_a = cyc - t0_a; end
        if (ferr_a) begin ferr_cnt_a++; ferr_at_a = cyc - t0_a; end
        if (busy_a) busy_last_a = cyc - t0_a;
        if (strobe_b) strb_b.push_back(cyc - t0_b);
        if (strobe_b && avail_b) sh_b = {line_b, sh_b[4:1]};
        if (valid_b) begin valid_cnt_b++; valid_at_b = cyc - t0_b; end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        strb_a.delete();
        strb_b.delete();
        sh_a = '0;
        sh_b = '0;
        valid_cnt_a = 0; valid_at_a = -1;
        ferr_cnt_a  = 0; ferr_at_a  = -1;
        busy_last_a = -1;
        valid_cnt_b = 0; valid_at_b = -1;
    endtask

    // Called on a negedge: set the line and hold it for n cycles
    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) line_a = v;
        else          line_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input int w, input int cpb,
                              input logic [7:0] d, input logic stop, input int idle_cyc);
        if (sel == 0) t0_a = cyc + 1;
        else          t0_b = cyc + 1;
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < w; i++) drive(sel, d[i], cpb);
        drive(sel, stop, cpb);
        if (idle_cyc > 0) drive(sel, 1'b1, idle_cyc);
    endtask

    task automatic check_strobes_a(input string tag, input int n);
        check({tag, "_nstrb"}, strb_a.size(), n);
        for (int k = 0; k < strb_a.size(); k++)
            check({tag, "_strb"}, strb_a[k], 8 + (k + 1) * 16);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        t0_a     = 0;
        t0_b     = 0;
        line_a   = 1'b1;
        line_b   = 1'b1;
        reset    = 1'b1;
        clear_rec();
        repeat (3) @(negedge clk);
        check("reset_outs_a", int'({strobe_a, avail_a, valid_a, ferr_a, busy_a}), 0);
        check("reset_outs_b", int'({strobe_b, avail_b, valid_b, ferr_b, busy_b}), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Nominal frame 0xA5
        clear_rec();
        send_frame(0, 8, 16, 8'hA5, 1'b1, 16);
        check_strobes_a("nominal", 9);
        check("nominal_valid_at", valid_at_a, 152);
        check("nominal_valid_cnt", valid_cnt_a, 1);
        check("nominal_ferr_cnt", ferr_cnt_a, 0);
        check("nominal_data", int'(sh_a), 8'hA5);
        check("nominal_busy_last", busy_last_a, 152);

        // Framing error 0x3C, then a held-low break
        clear_rec();
        send_frame(0, 8, 16, 8'h3C, 1'b0, 0);
        drive(0, 1'b0, 60);
        check("ferr_at", ferr_at_a, 152);
        check("ferr_cnt", ferr_cnt_a, 1);
        check("ferr_valid_cnt", valid_cnt_a, 0);
        check("ferr_data", int'(sh_a), 8'h3C);
        check("break_nstrb", strb_a.size(), 9);
        check("break_busy_last", busy_last_a, 152);
        check("break_busy_now", int'(busy_a), 0);
        drive(0, 1'b1, 20);
        clear_rec();
        send_frame(0, 8, 16, 8'h5A, 1'b1, 16);
        check("after_break_valid_at", valid_at_a, 152);
        check("after_break_data", int'(sh_a), 8'h5A);

        // Three-cycle glitch on the start bit
        clear_rec();
        t0_a = cyc + 1;
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 200);
`ifdef START_GLITCH_REJECT_EN
        check("glitch_nstrb", strb_a.size(), 0);
        check("glitch_busy_last", busy_last_a, 8);
        check("glitch_valid_cnt", valid_cnt_a, 0);
`else
        check_strobes_a("glitch", 9);
        check("glitch_valid_at", valid_at_a, 152);
        check("glitch_data", int'(sh_a), 8'hFF);
        check("glitch_busy_last", busy_last_a, 152);
`endif

        // Back-to-back frames with one idle bit between
        clear_rec();
        send_frame(0, 8, 16, 8'h00, 1'b1, 16);
        check_strobes_a("b2b0", 9);
        check("b2b0_valid_at", valid_at_a, 152);
        check("b2b0_data", int'(sh_a), 8'h00);
        clear_rec();
        send_frame(0, 8, 16, 8'hFF, 1'b1, 16);
        check_strobes_a("b2b1", 9);
        check("b2b1_valid_at", valid_at_a, 152);
        check("b2b1_data", int'(sh_a), 8'hFF);

        // Asynchronous reset mid-DATA aborts the frame
        clear_rec();
        t0_a = cyc + 1;
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16);
        drive(0, 1'b0, 16);
        check("pre_rst_avail_busy", int'({avail_a, busy_a}), 3);
        #1 reset = 1'b1;
        #1 check("rst_async_outs", int'({strobe_a, avail_a, valid_a, ferr_a, busy_a}), 0);
        line_a = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("rst_abort_valid", valid_cnt_a, 0);
        check("rst_abort_ferr", ferr_cnt_a, 0);
        check("rst_abort_busy", int'(busy_a), 0);
        clear_rec();
        send_frame(0, 8, 16, 8'h96, 1'b1, 16);
        check("post_rst_valid_at", valid_at_a, 152);
        check("post_rst_data", int'(sh_a), 8'h96);

        // Odd width: W=5, CPB=4, data 0b10110
        clear_rec();
        send_frame(1, 5, 4, 8'h16, 1'b1, 8);
        check("odd_nstrb", strb_b.size(), 6);
        for (int k = 0; k < strb_b.size(); k++)
            check("odd_strb", strb_b[k], 2 + (k + 1) * 4);
        check("odd_valid_at", valid_at_b, 26);
        check("odd_valid_cnt", valid_cnt_b, 1);
        check("odd_data", int'(sh_b), 5'h16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Receive-path sequencer for the UART Rx. It watches the already-synchronised serial line, detects the start bit, and times each bit with an internal oversampling counter. It produces the control strobes that drive the downstream SIPO shift register: `sampling_strobe`, `data_is_available` and `data_is_valid`. It also reports stop-bit framing errors.

## Interface
Parameters:
- `INPUT_DATA_WIDTH`, default 8: data bits per frame; must match the SIPO width.
- `CLKS_PER_BIT`, default 16: clk cycles per bit period; must be even and ≥ 4.

Ports:
- `clk`  in  1  single system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `serial_in_synced`  in  1  Rx line, already synchronised to `clk`; idle high.
- `sampling_strobe`  out  1  one-cycle pulse at the mid-point of each data bit and of the stop bit.
- `data_is_available`  out  1  high for the whole DATA state; SIPO shifts on `sampling_strobe && data_is_available`.
- `data_is_valid`  out  1  one-cycle pulse at mid-stop when the stop bit is high; the frame is complete.
- `framing_error`  out  1  one-cycle pulse at mid-stop when the stop bit is low.
- `rx_busy`  out  1  high in any state other than IDLE.

## Operation
- State machine has four states: IDLE, START, DATA, STOP. Reset state is IDLE.
- Registers:
  - `line_prev`: resets to 1 and captures `serial_in_synced` every cycle.
  - `clk_cnt`: width clog2(CLKS_PER_BIT), resets to 0.
  - `bit_cnt`: width clog2(INPUT_DATA_WIDTH+1), resets to 0.
- IDLE:
  - Start detect requires a falling edge: `line_prev==1 && serial_in_synced==0`.
  - On start detect, go to START and clear `clk_cnt`.
  - A line that stays low (break) never starts a frame.
- START:
  - `clk_cnt` counts up to CLKS_PER_BIT/2−1, which is the mid-start point.
  - At mid-start, go to DATA and clear `clk_cnt` and `bit_cnt`.
  - Glitch rejection at this point is governed by the macro in Configuration.
- DATA:
  - `clk_cnt` wraps at CLKS_PER_BIT−1.
  - On wrap, pulse `sampling_strobe` and increment `bit_cnt`.
  - After the INPUT_DATA_WIDTH-th strobe, go to STOP with `clk_cnt` cleared.
- STOP:
  - On `clk_cnt` wrap, pulse `sampling_strobe`.
  - If `serial_in_synced==1`, pulse `data_is_valid`; otherwise pulse `framing_error`.
  - Go to IDLE in the same step.
- `data_is_available` is a registered decode of state==DATA. It is low during the stop-bit strobe, so the SIPO does not shift the stop bit.
- `data_is_valid` and `framing_error` are never high together.
- All outputs are registered.
- Reset values:
  - All outputs 0.
  - `line_prev` 1.
  - Counters 0.
  - State IDLE.
- Reset asserted mid-frame aborts the frame with no `data_is_valid` and no `framing_error` pulse.

## Timing
- Cycle 0 is the first posedge at which IDLE sees `serial_in_synced==0` after a 1.
- Mid-start point: cycle H, where H = CLKS_PER_BIT/2.
- Data bit k (k = 0…W−1, LSB first) strobe: cycle H + (k+1)·CLKS_PER_BIT.
- Stop strobe, plus `data_is_valid` or `framing_error`: cycle H + (W+1)·CLKS_PER_BIT.
- `data_is_available` is high from cycle H+1 through the cycle of the last data strobe, inclusive.
- The FSM is back in IDLE one cycle after the stop strobe. The next frame can start on the next falling edge, which requires the line to be high for at least one cycle after IDLE is re-entered.
- `rx_busy` is high from cycle 1 up to and including the stop-strobe cycle.

## Configuration
- `START_GLITCH_REJECT_EN`:
  - Defined: at mid-start, if `serial_in_synced==1`, the FSM returns to IDLE. No strobes are produced and `rx_busy` drops the next cycle.
  - Undefined: the mid-start sample is ignored and the frame is always committed once the falling edge is seen.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-DATA.
  - All outputs go 0 before the next posedge and the state is IDLE.
  - A clean frame sent after reset is received correctly.
- **Nominal frame:** W=8, CPB=16; send 0xA5 with stop=1.
  - Strobes at cycles 24, 40, …, 136; stop strobe at 152.
  - `data_is_valid` pulses at 152 and the SIPO holds 0xA5.
- **Framing error:** send 0x3C with stop=0.
  - `framing_error` pulses at cycle 152 and `data_is_valid` stays 0.
  - The held-low line does not start a new frame until it returns high and then falls.
- **Glitch on start:** pull the line low for 3 cycles, then high.
  - With `START_GLITCH_REJECT_EN`: no strobes, and `rx_busy` is low from cycle 9.
  - Without it: 9 strobes occur and `data_is_valid` pulses at cycle 152 with data 0xFF.
- **Back-to-back:** send frames 0x00 and 0xFF with exactly one idle-high bit between them.
  - Both produce `data_is_valid` with the correct data.
  - Strobe spacing is exactly CPB within each frame.
- **Odd width:** W=5, CPB=4; send 0b10110.
  - 5 data strobes at cycles 6, 10, 14, 18, 22.
  - `data_is_valid` pulses at cycle 26.
